// File: rtl/bram_port_arb.sv
// rtl/bram_port_arb.sv - two-requester round-robin arbiter for one block RAM port
// Locked bursts are bounded by MAX_BURST, and registered read data is routed back to the issuer.
module bram_port_arb #(
  parameter int DATA      = 32,
  parameter int ADDR      = 7,
  parameter int MAX_BURST = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_wr,
  input  logic            m0_lock,
  input  logic [ADDR-1:0] m0_addr,
  input  logic [DATA-1:0] m0_wdata,
  output logic            m0_ack,
  output logic            m0_rvalid,
  output logic [DATA-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_wr,
  input  logic            m1_lock,
  input  logic [ADDR-1:0] m1_addr,
  input  logic [DATA-1:0] m1_wdata,
  output logic            m1_ack,
  output logic            m1_rvalid,
  output logic [DATA-1:0] m1_rdata,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic          last;
  logic          owner_valid;
  logic          owner;
  logic [CW-1:0] burst_cnt;
  logic          rpend;
  logic          rsel;

  logic gnt;
  logic ack_any;
  logic sel;
  logic g_wr;
  logic g_lock;

  // Lock only matters under contention; a lone requester always wins.
  always_comb begin
    gnt = ~last;
    if (m0_req && !m1_req)
      gnt = 1'b0;
    else if (m1_req && !m0_req)
      gnt = 1'b1;
    else if (owner_valid && (burst_cnt < CW'(MAX_BURST)))
      gnt = owner;
  end

  always_comb begin
    ack_any  = (m0_req | m1_req) & ~rst;
    m0_ack   = ack_any & ~gnt;
    m1_ack   = ack_any & gnt;
    g_wr     = gnt ? m1_wr : m0_wr;
    g_lock   = gnt ? m1_lock : m0_lock;
    sel      = ack_any ? gnt : last;
    mem_wr   = ack_any & g_wr;
    mem_addr = sel ? m1_addr : m0_addr;
    mem_din  = sel ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last        <= 1'b1;
      owner_valid <= 1'b0;
      owner       <= 1'b0;
      burst_cnt   <= '0;
      rpend       <= 1'b0;
      rsel        <= 1'b0;
    end else begin
      rpend <= ack_any & ~g_wr;
      rsel  <= gnt;
      if (ack_any) begin
        last        <= gnt;
        owner       <= gnt;
        owner_valid <= g_lock;
        if (gnt != last)
          burst_cnt <= CW'(1);
        else if (burst_cnt != CW'(MAX_BURST))
          burst_cnt <= burst_cnt + CW'(1);
      end else begin
        // No ack means nobody is requesting, so the owner has dropped req.
        owner_valid <= 1'b0;
      end
    end
  end

  assign m0_rvalid = rpend & ~rsel;
  assign m1_rvalid = rpend & rsel;
  assign m0_rdata  = mem_dout;
  assign m1_rdata  = mem_dout;

endmodule

// File: tb/tb_bram_port_arb.sv
// tb/tb_bram_port_arb.sv - directed self-checking bench for bram_port_arb
// A behavioural registered-read RAM sits on the arbitrated port.
module tb_bram_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m0_lock;
  logic [6:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_wr, m1_lock;
  logic [6:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_wr;
  logic [6:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] ram [0:127];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_port_arb #(.DATA(32), .ADDR(7), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic a0, a1;
    int   n0, m1_at, rv1;

    for (int i = 0; i < 128; i++) ram[i] = 32'h0;
    ram[5] = 32'hDEADBEEF;
    ram[1] = 32'h00000011;
    ram[2] = 32'h00000022;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_ack0", 32'(m0_ack), 0);
    chk("rst_ack1", 32'(m1_ack), 0);
    chk("rst_rv0", 32'(m0_rvalid), 0);
    chk("rst_rv1", 32'(m1_rvalid), 0);
    chk("rst_memwr", 32'(mem_wr), 0);
    @(posedge clk); #1;

    // 1: lone read of addr 5
    m0_req = 1; m0_wr = 0; m0_addr = 7'd5;
    @(negedge clk);
    chk("t1_ack0", 32'(m0_ack), 1);
    chk("t1_ack1", 32'(m1_ack), 0);
    chk("t1_rv0_early", 32'(m0_rvalid), 0);
    @(posedge clk); #1 m0_req = 0;
    @(negedge clk);
    chk("t1_rv0", 32'(m0_rvalid), 1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_rv1", 32'(m1_rvalid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_rv0_once", 32'(m0_rvalid), 0);
    @(posedge clk); #1;

    // 2: both reading continuously, no lock
    do_reset();
    m0_req = 1; m0_addr = 7'd1;
    m1_req = 1; m1_addr = 7'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_ack0", 32'(m0_ack), 32'((i % 2) == 0));
      chk("t2_ack1", 32'(m1_ack), 32'((i % 2) == 1));
      if (i > 0) begin
        chk("t2_rv0", 32'(m0_rvalid), 32'(((i - 1) % 2) == 0));
        chk("t2_rv1", 32'(m1_rvalid), 32'(((i - 1) % 2) == 1));
        chk("t2_rdata", mem_dout, (((i - 1) % 2) == 0) ? 32'h11 : 32'h22);
      end
      @(posedge clk); #1;
    end

    // 3: 20 locked writes from m0 against a waiting m1 read
    do_reset();
    n0 = 0; m1_at = -1; rv1 = 0;
    m0_req = 1; m0_wr = 1; m0_lock = 1; m0_addr = 7'd32; m0_wdata = 32'hA000;
    m1_req = 1; m1_wr = 0; m1_addr = 7'd2;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a0 = m0_ack; a1 = m1_ack;
      chk("t3_one_ack", 32'(a0 & a1), 0);
      if (m1_rvalid) begin
        rv1++;
        chk("t3_rdata", m1_rdata, 32'h22);
      end
      if (a1) m1_at = n0;
      if (a0) n0++;
      @(posedge clk); #1;
      if (a1) m1_req = 0;
      m0_addr  = 7'(32 + n0);
      m0_wdata = 32'hA000 + 32'(n0);
      if (n0 == 20) m0_req = 0;
    end
    chk("t3_m0_acks", 32'(n0), 20);
    chk("t3_m1_slot", 32'(m1_at), 16);
    chk("t3_rv1_cnt", 32'(rv1), 1);
    chk("t3_ram_first", ram[32], 32'hA000);
    chk("t3_ram_last", ram[51], 32'hA013);

    // 4: write then read same address on consecutive cycles
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = 7'd3; m0_wdata = 32'h12345678;
    @(negedge clk);
    chk("t4_wack", 32'(m0_ack), 1);
    chk("t4_memwr", 32'(mem_wr), 1);
    @(posedge clk); #1;
    m0_req = 0;
    m1_req = 1; m1_wr = 0; m1_addr = 7'd3;
    @(negedge clk);
    chk("t4_rack", 32'(m1_ack), 1);
    chk("t4_no_wrv", 32'(m0_rvalid), 0);
    @(posedge clk); #1 m1_req = 0;
    @(negedge clk);
    chk("t4_rv1", 32'(m1_rvalid), 1);
    chk("t4_rdata", m1_rdata, 32'h12345678);
    @(posedge clk); #1;

    // 5: reset lands right after a read ack
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 7'd5;
    @(negedge clk);
    chk("t5_ack", 32'(m0_ack), 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_ack_in_rst", 32'(m0_ack), 0);
    chk("t5_memwr_in_rst", 32'(mem_wr), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_rv0", 32'(m0_rvalid), 0);
    chk("t5_rv1", 32'(m1_rvalid), 0);
    @(posedge clk); #3 rst = 1'b0;
    m1_req = 1; m1_wr = 0; m1_addr = 7'd2;
    @(negedge clk);
    chk("t5_first_ack0", 32'(m0_ack), 1);
    chk("t5_first_ack1", 32'(m1_ack), 0);
    chk("t5_rv0_after", 32'(m0_rvalid), 0);
    @(posedge clk); #1 idle_inputs();

    // 6: m1 locked write burst, m0 aborts mid-way, then idle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m1_req = 1; m1_wr = 1; m1_lock = 1;
      m1_addr = 7'(10 + i); m1_wdata = 32'h100 + 32'(i);
      if (i == 3) begin
        m0_req = 1; m0_wr = 1; m0_addr = 7'd10; m0_wdata = 32'hBAD0BAD0;
      end
      if (i == 5) m0_req = 0;
      @(negedge clk);
      chk("t6_ack1", 32'(m1_ack), 1);
      chk("t6_ack0", 32'(m0_ack), 0);
      chk("t6_memwr", 32'(mem_wr), 1);
      @(posedge clk); #1;
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_idle_memwr", 32'(mem_wr), 0);
      chk("t6_idle_ack", 32'(m0_ack | m1_ack), 0);
      @(posedge clk); #1;
    end
    chk("t6_ram10", ram[10], 32'h100);
    chk("t6_ram17", ram[17], 32'h107);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arb.md
Name: bram_port_arb

Overview:
- Two-requester round-robin arbiter that shares a single port of the team's dual-port block RAM.
- Requester 0 is the SPI flash shift engine (page fill/drain); requester 1 is the host register/bus interface.
- Supports locked bursts with a bounded burst length so page transfers stay contiguous without starving the host.
- Routes the RAM's 1-cycle registered read data back to the requester that issued the read.

Parameters:
DATA, 32, data word width; must match the RAM.
ADDR, 7, word address width; must match the RAM.
MAX_BURST, 16, max consecutive grants to a locked owner while the other requester waits; must be >= 1.

Ports:
clk  in  1  single clock for arbiter and RAM port.
rst  in  1  asynchronous, active-high reset.
m0_req  in  1  requester 0 access request.
m0_wr  in  1  1 = write, 0 = read.
m0_lock  in  1  request to keep ownership for a burst.
m0_addr  in  ADDR  word address.
m0_wdata  in  DATA  write data.
m0_ack  out  1  access accepted this cycle.
m0_rvalid  out  1  read data valid for requester 0.
m0_rdata  out  DATA  read data.
m1_req, m1_wr, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: same as m0_*, for requester 1.
mem_wr  out  1  RAM port write enable.
mem_addr  out  ADDR  RAM port address.
mem_din  out  DATA  RAM port write data.
mem_dout  in  DATA  RAM port registered read data; valid 1 cycle after the address is presented.

Behaviour:
- Handshake:
  - A requester holds req, wr, lock, addr and wdata stable until it sees ack.
  - It may deassert req before ack (abort); no side effects.
  - ack is combinational from req plus registered arbiter state. At most one ack per cycle.
- RAM drive (combinational mux of the acked requester):
  - mem_wr = granted wr & ack.
  - mem_addr and mem_din come from the granted requester.
  - With no ack: mem_wr = 0; mem_addr/mem_din follow requester `last`.
- Read return:
  - Registered flags rsel/rpend capture {requester, read & ack}.
  - Next cycle, mX_rvalid = rpend & (rsel == X), asserted for exactly 1 cycle.
  - m0_rdata = m1_rdata = mem_dout, meaningful only while the matching rvalid is high.
  - Latency from ack to rvalid is 1 cycle. Back-to-back reads return in order, every cycle.
- Writes produce no rvalid.
  - Write-then-read of the same address in consecutive cycles returns the new data.
- Arbitration state:
  - last: 1 bit, last granted requester.
  - owner_valid, owner: lock holder.
  - burst_cnt: width clog2(MAX_BURST+1).
- Grant rules:
  - One requester only: it is granted.
  - Both requesting, owner_valid, and burst_cnt < MAX_BURST: owner is granted.
  - Otherwise: the requester != last is granted.
- On each ack:
  - last <= granted requester.
  - burst_cnt <= (granted == last) ? burst_cnt + 1 (saturating at MAX_BURST) : 1.
  - owner_valid <= granted lock; owner <= granted.
- Lock release:
  - Owner acked with lock = 0 clears ownership.
  - Owner dropping req also clears owner_valid the next cycle.
- A non-owner grant forced by burst_cnt == MAX_BURST:
  - Clears ownership unless that requester itself sets lock.
  - Previous owner then re-competes as a normal round-robin requester.
- Reset (asynchronous, any cycle):
  - last = 1 (requester 0 wins the first tie).
  - owner_valid = 0, burst_cnt = 0, rpend = 0; all rvalid = 0 immediately.
  - A read pending at reset is discarded.
  - ack and mem_wr are combinationally 0 while rst is high.

Test Plan:
1. RAM addr 5 preloaded 0xDEADBEEF; m0 reads addr 5 alone:
   - m0_ack in cycle N; m0_rvalid high in N+1 only, m0_rdata = 0xDEADBEEF.
   - m1_rvalid stays 0.
2. Both requesters hold req continuously, no lock, after reset:
   - Acks alternate m0, m1, m0, m1…; each read returns to the correct requester 1 cycle later.
3. MAX_BURST = 16; m0 issues 20 locked writes while m1 holds a read request:
   - m0 gets 16 consecutive acks, then m1 gets 1 ack, then m0 gets the remaining 4.
   - m1_rvalid fires exactly once.
4. m0 writes 0x12345678 to addr 3 in cycle N; m1 reads addr 3 in N+1:
   - m1_rvalid in N+2 with 0x12345678.
5. rst pulsed mid-cycle 1 cycle after a read ack:
   - rvalid never asserts.
   - After release with both requesting, m0 is acked first.
6. m1 alone writes 8 consecutive cycles, then goes idle:
   - ack every cycle, no bubbles.
   - mem_wr = 0 on every idle cycle; m0 abort (req dropped before ack) leaves RAM contents unchanged.
